// File: rtl/door_seq_pkg.sv
// Shared types and constants for the door-handle pulse sequencer:
// the sequencer state enum, the default command id, the decoded frame
// layout and the per-state pin level.
package door_seq_pkg;

  // Sequencer states. IDLE is encoded as 0 so a cleared register means idle.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HIGH = 3'd1,
    LOW  = 3'd2,
    IMP  = 3'd3,
    STOP = 3'd4,
    DONE = 3'd5
  } seq_state_t;

  // tele_byte value that identifies a pulse-sequence command frame.
  localparam logic [7:0] DEFAULT_CMD_ID = 8'hA5;

  // Decoded telemetry frame as delivered by the byte-capture stage.
  typedef struct packed {
    logic [7:0]  tele_byte;
    logic [7:0]  rep_no;
    logic [15:0] high_on;
    logic [15:0] low_on;
    logic [15:0] imp_on;
    logic [15:0] stop_on;
  } frame_t;

  // Level driven on the stimulus pin while a state is active.
  function automatic logic state_level(input seq_state_t s);
    return (s == HIGH) || (s == IMP);
  endfunction

endpackage

// File: rtl/door_pulse_sequencer_prescaler.sv
// tick_prescaler: divides clk down to the sequencer time base.
// tick is high on the last clk cycle of every TICK_DIV-cycle tick period.
// restart forces the count back to 0 on the next edge so a freshly entered
// phase always sees a full tick period before its first tick.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  // Free-running modulo-TICK_DIV counter, zeroed on restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/door_pulse_sequencer.sv
// door_pulse_sequencer: replays one decoded telemetry frame as a timed
// door-handle stimulus waveform on pulse_out.
//
// Build option: define SEQ_LOOP_EN to make rep_no=0 repeat HIGH/LOW/IMP
// forever (cur_rep wraps modulo 256); abort then runs STOP and DONE
// instead of dropping straight to IDLE.
//
// Handshake: frame_valid is a one-cycle strobe with all frame fields
// stable. A frame is taken only in IDLE; busy is high from the cycle after
// acceptance until the DONE cycle, where done pulses for one cycle and busy
// is already low. A strobe in any non-IDLE state (DONE included) is dropped
// and flagged on overrun. There is no back-pressure on the capture stage.
module door_pulse_sequencer
  import door_seq_pkg::*;
#(
  parameter int         TICK_DIV = 1000,
  parameter logic [7:0] CMD_ID   = DEFAULT_CMD_ID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [7:0]  tele_byte,
  input  logic [7:0]  rep_no,
  input  logic [15:0] high_on,
  input  logic [15:0] low_on,
  input  logic [15:0] imp_on,
  input  logic [15:0] stop_on,
  input  logic        abort,
  output logic        pulse_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cur_rep,
  output logic        cmd_err,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  seq_state_t  state, state_nxt;
  frame_t      fr, in_frame;
  logic        fr_seen;
  logic [15:0] cnt, load_val;
  logic        tick, load, phase_end;
  logic        fr_load, accept, imp_end, rep_inc, ovr_set, loop_mode;

  // First phase of a repetition; zero-length phases are skipped. With all
  // three lengths zero the repetition still takes one IMP bookkeeping cycle.
  function automatic seq_state_t rep_entry(input logic [15:0] h,
                                           input logic [15:0] l);
    if (h != 16'd0)      return HIGH;
    else if (l != 16'd0) return LOW;
    else                 return IMP;
  endfunction

  // Trailing phase: STOP, or straight to DONE when it has zero length.
  function automatic seq_state_t stop_entry(input logic [15:0] s);
    return (s != 16'd0) ? STOP : DONE;
  endfunction

  // Tick count loaded into the phase counter when a state is entered.
  function automatic logic [15:0] phase_len(input seq_state_t st,
                                            input logic [15:0] h,
                                            input logic [15:0] l,
                                            input logic [15:0] i,
                                            input logic [15:0] s);
    case (st)
      HIGH:    return h;
      LOW:     return l;
      IMP:     return i;
      STOP:    return s;
      default: return 16'd0;
    endcase
  endfunction

  assign in_frame = '{tele_byte: tele_byte, rep_no: rep_no,
                      high_on: high_on, low_on: low_on,
                      imp_on: imp_on, stop_on: stop_on};

  // Endless repetition only applies to a latched rep_no of zero.
  assign loop_mode = LOOP_EN && (fr.rep_no == 8'd0);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (load),
    .tick    (tick)
  );

  // Next-state logic: phase sequencing, zero-length skipping, abort.
  always_comb begin
    state_nxt = state;
    fr_load   = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    imp_end   = 1'b0;
    rep_inc   = 1'b0;
    ovr_set   = 1'b0;
    load_val  = 16'd0;
    // A phase ends on the tick that takes its counter from 1 to 0; a
    // counter loaded with 0 (all-zero repetition) ends at once.
    phase_end = (cnt == 16'd0) || (tick && (cnt == 16'd1));

    case (state)
      IDLE: begin
        if (frame_valid) begin
          fr_load = 1'b1;
          if (tele_byte == CMD_ID) begin
            accept = 1'b1;
            load   = 1'b1;
            if ((rep_no == 8'd0) && !LOOP_EN) state_nxt = stop_entry(stop_on);
            else                              state_nxt = rep_entry(high_on, low_on);
          end
        end
      end
      HIGH: begin
        if (phase_end) begin
          load = 1'b1;
          if (fr.low_on != 16'd0)      state_nxt = LOW;
          else if (fr.imp_on != 16'd0) state_nxt = IMP;
          else                         imp_end   = 1'b1;
        end
      end
      LOW: begin
        if (phase_end) begin
          load = 1'b1;
          if (fr.imp_on != 16'd0) state_nxt = IMP;
          else                    imp_end   = 1'b1;
        end
      end
      IMP: begin
        if (phase_end) begin
          load    = 1'b1;
          imp_end = 1'b1;
        end
      end
      STOP: begin
        if (phase_end) begin
          load      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // End of a repetition: count it and decide between another one and STOP.
    if (imp_end) begin
      rep_inc = 1'b1;
      if (loop_mode || (({1'b0, cur_rep} + 9'd1) < {1'b0, fr.rep_no}))
        state_nxt = rep_entry(fr.high_on, fr.low_on);
      else
        state_nxt = stop_entry(fr.stop_on);
    end

    if (frame_valid && (state != IDLE)) ovr_set = 1'b1;

    // Abort wins over everything else. In endless mode it finishes through
    // STOP/DONE; otherwise it drops to IDLE with no done strobe.
    if (abort && (state != IDLE)) begin
      rep_inc = 1'b0;
      if (loop_mode && (state inside {HIGH, LOW, IMP})) begin
        load      = 1'b1;
        state_nxt = stop_entry(fr.stop_on);
      end else if (!(loop_mode && (state inside {STOP, DONE}))) begin
        load      = 1'b0;
        state_nxt = IDLE;
      end
    end

    if (accept)
      load_val = phase_len(state_nxt, high_on, low_on, imp_on, stop_on);
    else
      load_val = phase_len(state_nxt, fr.high_on, fr.low_on, fr.imp_on, fr.stop_on);
  end

  // State register and latched frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      fr      <= '0;
      fr_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fr_load) begin
        fr      <= in_frame;
        fr_seen <= 1'b1;
      end
    end
  end

  // Phase counter: load on phase entry, count down on each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != 16'd0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  // Repetition counter and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_rep <= 8'd0;
      overrun <= 1'b0;
    end else begin
      if (accept)       cur_rep <= 8'd0;
      else if (rep_inc) cur_rep <= cur_rep + 8'd1;
      if (accept)       overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
    end
  end

  // Registered pin and status outputs, decoded from the next state so they
  // line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse_out <= state_level(state_nxt);
      busy      <= (state_nxt inside {HIGH, LOW, IMP, STOP});
      done      <= (state_nxt == DONE);
    end
  end

  // The last latched frame is kept, so rejection is read straight from it.
  assign cmd_err   = fr_seen && (fr.tele_byte != CMD_ID);
  assign dbg_state = state;

endmodule

// File: tb/tb_door_pulse_sequencer.sv
// Bench for door_pulse_sequencer. Two instances share the frame fields:
// dut4 (TICK_DIV=4) and dut1 (TICK_DIV=1), each with its own strobe and
// abort. The expected waveform of a frame is expanded into exp_q as one
// {pulse, cur_rep} entry per clk cycle.
module tb_door_pulse_sequencer;
  import door_seq_pkg::*;

  localparam logic [7:0] CMD = 8'hA5;
`ifdef SEQ_LOOP_EN
  localparam int REP_MIN = 1;
`else
  localparam int REP_MIN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fv4, fv1, abort4, abort1;
  logic [7:0]  tele_byte, rep_no;
  logic [15:0] high_on, low_on, imp_on, stop_on;

  logic        pulse4, busy4, done4, cmd_err4, overrun4;
  logic [7:0]  cur_rep4;
  logic [2:0]  dbg4;
  logic        pulse1, busy1, done1, cmd_err1, overrun1;
  logic [7:0]  cur_rep1;
  logic [2:0]  dbg1;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [8:0]  exp_q[$];
  logic        exp_cmd_err[2];
  logic        exp_ovr[2];
  logic [7:0]  model_rep;
  logic [7:0]  r_rep;
  logic [15:0] r_h, r_l, r_i, r_s;
  int          r_inj;

  // clock
  always #5 clk = ~clk;

  door_pulse_sequencer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .frame_valid(fv4), .tele_byte(tele_byte),
    .rep_no(rep_no), .high_on(high_on), .low_on(low_on), .imp_on(imp_on),
    .stop_on(stop_on), .abort(abort4), .pulse_out(pulse4), .busy(busy4),
    .done(done4), .cur_rep(cur_rep4), .cmd_err(cmd_err4),
    .overrun(overrun4), .dbg_state(dbg4)
  );

  door_pulse_sequencer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .frame_valid(fv1), .tele_byte(tele_byte),
    .rep_no(rep_no), .high_on(high_on), .low_on(low_on), .imp_on(imp_on),
    .stop_on(stop_on), .abort(abort1), .pulse_out(pulse1), .busy(busy1),
    .done(done1), .cur_rep(cur_rep1), .cmd_err(cmd_err1),
    .overrun(overrun1), .dbg_state(dbg1)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [12:0] obs(input int which);
    if (which == 1) return {pulse1, busy1, done1, cur_rep1, cmd_err1, overrun1};
    return {pulse4, busy4, done4, cur_rep4, cmd_err4, overrun4};
  endfunction

  task automatic check_cycle(input int which, input string tag, input logic p,
                             input logic b, input logic d, input logic [7:0] r);
    logic [12:0] o;
    o = obs(which);
    chk({tag, ".pulse"},   16'(o[12]),  16'(p));
    chk({tag, ".busy"},    16'(o[11]),  16'(b));
    chk({tag, ".done"},    16'(o[10]),  16'(d));
    chk({tag, ".cur_rep"}, 16'(o[9:2]), 16'(r));
    chk({tag, ".cmd_err"}, 16'(o[1]),   16'(exp_cmd_err[which]));
    chk({tag, ".overrun"}, 16'(o[0]),   16'(exp_ovr[which]));
  endtask

  // Reference model: each repetition is high_on ticks high, low_on ticks
  // low, imp_on ticks high (one high cycle if all three are zero), then
  // stop_on ticks low. cur_rep counts the repetitions already finished.
  task automatic build_model(input int td, input int rep, input int h,
                             input int l, input int i, input int s);
    exp_q.delete();
    for (int r = 0; r < rep; r++) begin
      if (h + l + i == 0) begin
        exp_q.push_back({1'b1, 8'(r)});
      end else begin
        repeat (h * td) exp_q.push_back({1'b1, 8'(r)});
        repeat (l * td) exp_q.push_back({1'b0, 8'(r)});
        repeat (i * td) exp_q.push_back({1'b1, 8'(r)});
      end
    end
    repeat (s * td) exp_q.push_back({1'b0, 8'(rep)});
    model_rep = 8'(rep);
  endtask

  // driver: one-cycle frame strobe, then bench-side flag bookkeeping
  task automatic start_frame(input int which, input logic [7:0] tb,
                             input logic [7:0] rep, input logic [15:0] h,
                             input logic [15:0] l, input logic [15:0] i,
                             input logic [15:0] s);
    tele_byte = tb; rep_no = rep; high_on = h; low_on = l; imp_on = i; stop_on = s;
    if (which == 1) fv1 = 1'b1; else fv4 = 1'b1;
    @(posedge clk); #1;
    fv1 = 1'b0; fv4 = 1'b0;
    if (tb == CMD) begin
      exp_cmd_err[which] = 1'b0;
      exp_ovr[which]     = 1'b0;
    end else begin
      exp_cmd_err[which] = 1'b1;
    end
  endtask

  // Walk the expected queue cycle by cycle; optionally fire a junk frame
  // strobe during cycle inject_at, which must only raise overrun.
  task automatic play(input int which, input int max_cycles,
                      input int inject_at, input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0) && ((max_cycles < 0) || (k < max_cycles))) begin
      logic [8:0] e;
      if (k == inject_at) begin
        if (which == 1) fv1 = 1'b1; else fv4 = 1'b1;
        tele_byte = CMD;
        rep_no    = 8'($urandom);
        high_on   = 16'($urandom);
        low_on    = 16'($urandom);
        imp_on    = 16'($urandom);
        stop_on   = 16'($urandom);
      end
      e = exp_q.pop_front();
      @(negedge clk);
      check_cycle(which, tag, e[8], 1'b1, 1'b0, e[7:0]);
      @(posedge clk); #1;
      if (k == inject_at) begin
        fv1 = 1'b0; fv4 = 1'b0;
        exp_ovr[which] = 1'b1;
      end
      k++;
    end
  endtask

  task automatic finish_seq(input int which, input string tag);
    @(negedge clk);
    check_cycle(which, {tag, ".end"}, 1'b0, 1'b0, 1'b1, model_rep);
    @(posedge clk); #1;
    @(negedge clk);
    check_cycle(which, {tag, ".after"}, 1'b0, 1'b0, 1'b0, model_rep);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; fv4 = 1'b0; fv1 = 1'b0; abort4 = 1'b0; abort1 = 1'b0;
    tele_byte = 8'h00; rep_no = 8'h00;
    high_on = 16'd0; low_on = 16'd0; imp_on = 16'd0; stop_on = 16'd0;
    exp_cmd_err[0] = 1'b0; exp_cmd_err[1] = 1'b0;
    exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cycle(0, "reset4", 1'b0, 1'b0, 1'b0, 8'd0);
    check_cycle(1, "reset1", 1'b0, 1'b0, 1'b0, 8'd0);
    chk("reset4.state", 16'(dbg4), 16'(IDLE));
    chk("reset1.state", 16'(dbg1), 16'(IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // reference frame: 12H 8L 4H 12H 8L 4H 20L, then done
    build_model(4, 2, 3, 2, 1, 5);
    start_frame(0, CMD, 8'd2, 16'd3, 16'd2, 16'd1, 16'd5);
    play(0, -1, -1, "plan");
    finish_seq(0, "plan");

    // wrong command byte: rejected, stays idle
    start_frame(0, 8'h3C, 8'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    repeat (3) begin
      @(negedge clk);
      check_cycle(0, "cmderr", 1'b0, 1'b0, 1'b0, 8'd2);
      @(posedge clk); #1;
    end

    // valid frame clears cmd_err; strobe 10 cycles in only sets overrun
    build_model(4, 1, 2, 2, 2, 1);
    start_frame(0, CMD, 8'd1, 16'd2, 16'd2, 16'd2, 16'd1);
    play(0, -1, 10, "ovr");
    finish_seq(0, "ovr");

    // zero high/low phases at TICK_DIV=1: six contiguous high cycles
    build_model(1, 3, 0, 0, 2, 0);
    start_frame(1, CMD, 8'd3, 16'd0, 16'd0, 16'd2, 16'd0);
    play(1, -1, -1, "zero");
    finish_seq(1, "zero");

    // abort in the HIGH phase of the first repetition (also clears overrun)
    build_model(4, 3, 4, 1, 1, 1);
    start_frame(0, CMD, 8'd3, 16'd4, 16'd1, 16'd1, 16'd1);
    play(0, 5, -1, "abort");
    abort4 = 1'b1;
    @(posedge clk); #1;
    abort4 = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_cycle(0, "abort.idle", 1'b0, 1'b0, 1'b0, 8'd0);
      @(posedge clk); #1;
    end

    // randomized frames against the model
    for (int n = 0; n < 12; n++) begin
      r_rep = 8'($urandom_range(3, REP_MIN));
      r_h   = 16'($urandom_range(3, 0));
      r_l   = 16'($urandom_range(3, 0));
      r_i   = 16'($urandom_range(3, 0));
      r_s   = 16'($urandom_range(3, 0));
      r_inj = ($urandom_range(1, 0) == 1) ? 0 : -1;
      build_model(4, int'(r_rep), int'(r_h), int'(r_l), int'(r_i), int'(r_s));
      start_frame(0, CMD, r_rep, r_h, r_l, r_i, r_s);
      play(0, -1, r_inj, "rand");
      finish_seq(0, "rand");
    end

    // asynchronous reset in the STOP phase, with overrun already set
    build_model(4, 1, 1, 1, 1, 4);
    start_frame(0, CMD, 8'd1, 16'd1, 16'd1, 16'd1, 16'd4);
    play(0, 20, 2, "rstmid");
    exp_q.delete();
    #2 rst = 1'b0;
    exp_cmd_err[0] = 1'b0;
    exp_ovr[0]     = 1'b0;
    #1;
    check_cycle(0, "rst.async", 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_cycle(0, "rst.hold", 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef SEQ_LOOP_EN
    // endless repetition: 300 reps of 2 high cycles, cur_rep wraps at 256
    exp_q.delete();
    for (int k = 0; k < 600; k++) exp_q.push_back({1'b1, 8'((k / 2) % 256)});
    start_frame(1, CMD, 8'd0, 16'd1, 16'd0, 16'd1, 16'd2);
    play(1, -1, -1, "loop");
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    model_rep = 8'(300 % 256);
    repeat (2) begin
      @(negedge clk);
      check_cycle(1, "loop.stop", 1'b0, 1'b1, 1'b0, model_rep);
      @(posedge clk); #1;
    end
    finish_seq(1, "loop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
